// File: rtl/nn_pkg.sv
// Shared definitions for the NN training datapath: sample width, the
// scheduler state encoding and the default watchdog limit.
package nn_pkg;

  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PULSE,
    S_WAIT,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/nn_sched_wdog.sv
// Watchdog for the scheduler's WAIT state: a counter that is cleared on
// request, advances while enabled and flags when it reaches TIMEOUT-1.
module nn_sched_wdog
  #(parameter int TIMEOUT = nn_pkg::TIMEOUT)
  (
    input  logic clk,
    input  logic res,
    input  logic clr,
    input  logic en,
    output logic tc
  );

  import nn_pkg::*;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles since the last clear, parking at the terminal value
  always_ff @(posedge clk) begin
    if (!res) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign tc = (cnt == CNT_LAST);

endmodule

// File: rtl/nn_train_sched.sv
// Training-sequence controller for NN_CORE. Walks the sample store, loads
// each sample pair into the core, pulses update_coeff and waits for the
// core to finish, repeating for N_EPOCHS epochs under a watchdog.
module nn_train_sched
  #(parameter int N_SAMPLES = 4,
    parameter int ADDR_W    = 2,
    parameter int N_EPOCHS  = 10000,
    parameter int EPOCH_W   = 16,
    parameter int TIMEOUT   = nn_pkg::TIMEOUT,
    parameter int DATA_W    = nn_pkg::DATA_W)
  (
    input  logic               clk,
    input  logic               res,
    input  logic               start,
    input  logic               abort,
    output logic [ADDR_W-1:0]  smp_addr,
    input  logic [DATA_W-1:0]  smp_k1,
    input  logic [DATA_W-1:0]  smp_k2,
    output logic [DATA_W-1:0]  core_input_k_1,
    output logic [DATA_W-1:0]  core_input_k_2,
    output logic               core_update_coeff,
    input  logic               core_finish_updating,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic [ADDR_W-1:0]  sample_idx
  );

  import nn_pkg::*;

  localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(N_SAMPLES - 1);
  localparam logic [ADDR_W-1:0]  IDX_ONE    = ADDR_W'(1);
  localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(N_EPOCHS);
  localparam logic [EPOCH_W-1:0] EPOCH_ONE  = EPOCH_W'(1);

  sched_state_t       state;
  sched_state_t       state_nxt;
  logic [ADDR_W-1:0]  sample_idx_nxt;
  logic [ADDR_W-1:0]  smp_addr_nxt;
  logic [EPOCH_W-1:0] epoch_nxt;
  logic [DATA_W-1:0]  k1_nxt;
  logic [DATA_W-1:0]  k2_nxt;
  logic               err_nxt;
  logic               update_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               wdog_clr;
  logic               wdog_en;
  logic               wdog_tc;

  nn_sched_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk (clk),
    .res (res),
    .clr (wdog_clr),
    .en  (wdog_en),
    .tc  (wdog_tc)
  );

  // State and every output are registered; the outputs are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!res) begin
      state             <= S_IDLE;
      smp_addr          <= '0;
      core_input_k_1    <= '0;
      core_input_k_2    <= '0;
      core_update_coeff <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      epoch_cnt         <= '0;
      sample_idx        <= '0;
    end else begin
      state             <= state_nxt;
      smp_addr          <= smp_addr_nxt;
      core_input_k_1    <= k1_nxt;
      core_input_k_2    <= k2_nxt;
      core_update_coeff <= update_nxt;
      busy              <= busy_nxt;
      done              <= done_nxt;
      err               <= err_nxt;
      epoch_cnt         <= epoch_nxt;
      sample_idx        <= sample_idx_nxt;
    end
  end

  // Next-state, counter and output decode; abort outside IDLE freezes the
  // counters and sample registers and simply returns to IDLE.
  always_comb begin
    state_nxt      = state;
    sample_idx_nxt = sample_idx;
    epoch_nxt      = epoch_cnt;
    err_nxt        = err;
    k1_nxt         = core_input_k_1;
    k2_nxt         = core_input_k_2;
    wdog_clr       = 1'b0;
    wdog_en        = 1'b0;

    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            sample_idx_nxt = '0;
            epoch_nxt      = '0;
            err_nxt        = 1'b0;
            state_nxt      = S_FETCH;
          end
        end
        S_FETCH: begin
          state_nxt = S_LOAD;
        end
        S_LOAD: begin
          k1_nxt    = smp_k1;
          k2_nxt    = smp_k2;
          state_nxt = S_PULSE;
        end
        S_PULSE: begin
          wdog_clr  = 1'b1;
          state_nxt = S_WAIT;
        end
        S_WAIT: begin
          wdog_en = 1'b1;
          if (core_finish_updating) begin
            if (sample_idx == LAST_IDX) begin
              sample_idx_nxt = '0;
              epoch_nxt      = epoch_cnt + EPOCH_ONE;
            end else begin
              sample_idx_nxt = sample_idx + IDX_ONE;
            end
            state_nxt = (epoch_nxt == EPOCH_LAST) ? S_DONE : S_FETCH;
          end else if (wdog_tc) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    smp_addr_nxt = (state_nxt == S_FETCH) ? sample_idx_nxt : smp_addr;
    update_nxt   = (state_nxt == S_PULSE);
    busy_nxt     = (state_nxt != S_IDLE);
    done_nxt     = (state_nxt == S_DONE);
  end

endmodule

// File: tb/tb_nn_train_sched.sv
// Self-checking bench for nn_train_sched: a sample store with one-cycle
// read latency, a behavioural core that answers each update pulse, and a
// scoreboard of the sample pairs expected at every update pulse.
module tb_nn_train_sched;

  localparam int N_SAMPLES = 4;
  localparam int ADDR_W    = 2;
  localparam int N_EPOCHS  = 2;
  localparam int EPOCH_W   = 16;
  localparam int TIMEOUT   = 32;
  localparam int DATA_W    = 16;
  localparam int CORE_LAT  = 13;
  localparam int PULSE_GAP = 4 + CORE_LAT;

  typedef struct packed {
    logic [DATA_W-1:0] k1;
    logic [DATA_W-1:0] k2;
  } pair_t;

  logic               clk;
  logic               res;
  logic               start;
  logic               abort;
  logic [ADDR_W-1:0]  smp_addr;
  logic [DATA_W-1:0]  smp_k1;
  logic [DATA_W-1:0]  smp_k2;
  logic [DATA_W-1:0]  core_input_k_1;
  logic [DATA_W-1:0]  core_input_k_2;
  logic               core_update_coeff;
  logic               core_finish_updating;
  logic               busy;
  logic               done;
  logic               err;
  logic [EPOCH_W-1:0] epoch_cnt;
  logic [ADDR_W-1:0]  sample_idx;

  logic [DATA_W-1:0]  mem_k1 [N_SAMPLES];
  logic [DATA_W-1:0]  mem_k2 [N_SAMPLES];
  logic [ADDR_W-1:0]  addr_q;

  pair_t exp_q[$];
  pair_t mon_e;
  int    pulse_cyc[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  int    done_cnt    = 0;
  int    model_cnt   = 0;
  logic  model_respond = 1'b1;
  logic  model_finish  = 1'b0;
  logic  spur_finish   = 1'b0;
  int    t0;
  int    d0;

  assign core_finish_updating = model_finish | spur_finish;

  nn_train_sched #(
    .N_SAMPLES (N_SAMPLES),
    .ADDR_W    (ADDR_W),
    .N_EPOCHS  (N_EPOCHS),
    .EPOCH_W   (EPOCH_W),
    .TIMEOUT   (TIMEOUT),
    .DATA_W    (DATA_W)
  ) dut (
    .clk                  (clk),
    .res                  (res),
    .start                (start),
    .abort                (abort),
    .smp_addr             (smp_addr),
    .smp_k1               (smp_k1),
    .smp_k2               (smp_k2),
    .core_input_k_1       (core_input_k_1),
    .core_input_k_2       (core_input_k_2),
    .core_update_coeff    (core_update_coeff),
    .core_finish_updating (core_finish_updating),
    .busy                 (busy),
    .done                 (done),
    .err                  (err),
    .epoch_cnt            (epoch_cnt),
    .sample_idx           (sample_idx)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time-stamp events
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Hard bound on total run time
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] aborting");
  end

  // Sample store: the address seen after one edge returns data after the next
  initial begin
    smp_k1 = '0;
    smp_k2 = '0;
    addr_q = '0;
    forever begin
      @(posedge clk);
      #1;
      smp_k1 = mem_k1[addr_q];
      smp_k2 = mem_k2[addr_q];
      addr_q = smp_addr;
    end
  end

  // Core model: finish rises CORE_LAT cycles after the pulse cycle ends
  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_finish = 1'b0;
      if (model_cnt != 0) begin
        model_cnt--;
        if (model_cnt == 0) model_finish = model_respond;
      end
      if (core_update_coeff === 1'b1) model_cnt = CORE_LAT + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every update pulse pops the scoreboard and checks the core inputs
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (core_update_coeff === 1'b1) begin
        pulse_cyc.push_back(cyc);
        checkOutput("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("pulse_k1", 32'(core_input_k_1), 32'(mon_e.k1));
          checkOutput("pulse_k2", 32'(core_input_k_2), 32'(mon_e.k2));
        end
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic pushSample(input int idx);
    pair_t p;
    p.k1 = mem_k1[idx];
    p.k2 = mem_k2[idx];
    exp_q.push_back(p);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"},   32'(busy), 32'd0);
    checkOutput({tag, "_done"},   32'(done), 32'd0);
    checkOutput({tag, "_err"},    32'(err), 32'd0);
    checkOutput({tag, "_coeff"},  32'(core_update_coeff), 32'd0);
    checkOutput({tag, "_epoch"},  32'(epoch_cnt), 32'd0);
    checkOutput({tag, "_idx"},    32'(sample_idx), 32'd0);
    checkOutput({tag, "_addr"},   32'(smp_addr), 32'd0);
    checkOutput({tag, "_k1"},     32'(core_input_k_1), 32'd0);
    checkOutput({tag, "_k2"},     32'(core_input_k_2), 32'd0);
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) break;
      tick();
    end
    checkOutput("done_seen", 32'(done), 32'd1);
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) break;
      tick();
    end
    checkOutput("idle_seen", 32'(busy), 32'd0);
  endtask

  // Directed sequence
  initial begin
    res   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mem_k1[0] = 16'h0000; mem_k2[0] = 16'h0000;
    mem_k1[1] = 16'h0000; mem_k2[1] = 16'h0100;
    mem_k1[2] = 16'h0100; mem_k2[2] = 16'h0000;
    mem_k1[3] = 16'h0100; mem_k2[3] = 16'h0100;

    // Reset state
    repeat (3) tick();
    checkReset("rst");
    res = 1'b1;
    tick();
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

    // Spurious finish in IDLE is ignored
    spur_finish = 1'b1;
    tick();
    spur_finish = 1'b0;
    tick();
    checkOutput("idle_spur_busy", 32'(busy), 32'd0);
    checkOutput("idle_spur_idx", 32'(sample_idx), 32'd0);

    // Normal run: two epochs over the store
    for (int e = 0; e < N_EPOCHS; e++)
      for (int s = 0; s < N_SAMPLES; s++) pushSample(s);
    pulse_cyc.delete();
    d0 = done_cnt;
    t0 = cyc;
    applyStimulus(1'b1, 1'b0);
    checkOutput("run_busy", 32'(busy), 32'd1);
    checkOutput("run_addr", 32'(smp_addr), 32'd0);
    waitDone(400);
    checkOutput("done_cycle", 32'(cyc - t0), 32'(3 + 7 * PULSE_GAP + CORE_LAT + 2));
    checkOutput("run_epoch", 32'(epoch_cnt), 32'(N_EPOCHS));
    checkOutput("run_idx", 32'(sample_idx), 32'd0);
    checkOutput("run_err", 32'(err), 32'd0);
    checkOutput("busy_with_done", 32'(busy), 32'd1);
    tick();
    checkOutput("busy_fall", 32'(busy), 32'd0);
    checkOutput("done_fall", 32'(done), 32'd0);
    repeat (3) tick();
    checkOutput("pulse_count", 32'(pulse_cyc.size()), 32'(N_EPOCHS * N_SAMPLES));
    checkOutput("first_pulse", 32'((pulse_cyc.size() > 0) ? pulse_cyc[0] - t0 : -1), 32'd3);
    checkOutput("pulse_gap", 32'((pulse_cyc.size() > 1) ? pulse_cyc[1] - pulse_cyc[0] : -1), 32'(PULSE_GAP));
    checkOutput("epoch_gap", 32'((pulse_cyc.size() > 4) ? pulse_cyc[4] - pulse_cyc[3] : -1), 32'(PULSE_GAP));
    checkOutput("done_count", 32'(done_cnt - d0), 32'd1);
    checkOutput("sb_drained_run", 32'(exp_q.size()), 32'd0);

    // Watchdog: the core never answers
    model_respond = 1'b0;
    pushSample(0);
    d0 = done_cnt;
    t0 = cyc;
    applyStimulus(1'b1, 1'b0);
    waitIdle(100);
    checkOutput("wdog_cycle", 32'(cyc - t0), 32'(4 + TIMEOUT));
    checkOutput("wdog_err", 32'(err), 32'd1);
    checkOutput("wdog_idx", 32'(sample_idx), 32'd0);
    checkOutput("wdog_no_done", 32'(done_cnt - d0), 32'd0);
    model_respond = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("err_cleared", 32'(err), 32'd0);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_fetch_busy", 32'(busy), 32'd0);
    checkOutput("abort_fetch_coeff", 32'(core_update_coeff), 32'd0);

    // Abort in the same cycle as the third finish
    for (int s = 0; s < 3; s++) pushSample(s);
    pulse_cyc.delete();
    d0 = done_cnt;
    applyStimulus(1'b1, 1'b0);
    repeat (2 * PULSE_GAP + CORE_LAT + 3) tick();
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_idx", 32'(sample_idx), 32'd2);
    checkOutput("abort_epoch", 32'(epoch_cnt), 32'd0);
    checkOutput("abort_coeff", 32'(core_update_coeff), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    repeat (20) tick();
    checkOutput("abort_no_done", 32'(done_cnt - d0), 32'd0);
    checkOutput("abort_pulses", 32'(pulse_cyc.size()), 32'd3);
    checkOutput("abort_stays_idle", 32'(busy), 32'd0);

    // Start together with abort in IDLE stays IDLE
    applyStimulus(1'b1, 1'b1);
    checkOutput("start_abort_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("start_abort_busy2", 32'(busy), 32'd0);
    checkOutput("start_abort_coeff", 32'(core_update_coeff), 32'd0);

    // Reset for one cycle in the WAIT of the second sample
    pushSample(0);
    pushSample(1);
    applyStimulus(1'b1, 1'b0);
    repeat (PULSE_GAP + 7) tick();
    checkOutput("pre_rst_k2", 32'(core_input_k_2), 32'h0100);
    res = 1'b0;
    tick();
    res = 1'b1;
    checkReset("midrst");
    repeat (15) tick();
    checkOutput("late_finish_busy", 32'(busy), 32'd0);
    checkOutput("late_finish_idx", 32'(sample_idx), 32'd0);

    // Negative samples pass bit-exact; finish during PULSE is ignored
    mem_k1[0] = 16'hFF00;
    mem_k2[0] = 16'h8000;
    pushSample(0);
    applyStimulus(1'b1, 1'b0);
    tick();
    tick();
    checkOutput("neg_pulse", 32'(core_update_coeff), 32'd1);
    spur_finish = 1'b1;
    tick();
    spur_finish = 1'b0;
    checkOutput("pulse_spur_idx", 32'(sample_idx), 32'd0);
    checkOutput("pulse_spur_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("pulse_spur_idx2", 32'(sample_idx), 32'd0);
    checkOutput("neg_k1", 32'(core_input_k_1), 32'h0000FF00);
    checkOutput("neg_k2", 32'(core_input_k_2), 32'h00008000);
    applyStimulus(1'b0, 1'b1);
    checkOutput("neg_abort_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    checkOutput("sb_drained_end", 32'(exp_q.size()), 32'd0);
    checkOutput("total_done", 32'(done_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nn_train_sched.md
# nn_train_sched

Training-sequence controller that drives `NN_CORE`. It fetches input sample pairs from an external sample store and presents them to the core's `input_k_1` and `input_k_2`. For each sample it issues an `update_coeff` pulse, then waits for `finish_updating`. It repeats over all samples for a programmed number of epochs and guards every update with a watchdog, which replaces free-running stimulus as the top-level sequencer of the network datapath.

## Interface
Parameters:
- `N_SAMPLES`, 4: samples per epoch; must be ≥ 1.
- `ADDR_W`, 2: sample-store address width; 2^ADDR_W ≥ N_SAMPLES.
- `N_EPOCHS`, 10000: epochs per run; must be ≥ 1.
- `EPOCH_W`, 16: epoch counter width.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before error.
- `DATA_W`, 16: signed sample width.

Ports:
- `clk`, in, 1: clock, rising edge.
- `res`, in, 1: synchronous active-low reset.
- `start`, in, 1: begin run; honoured only in IDLE.
- `abort`, in, 1: stop run; return to IDLE.
- `smp_addr`, out, ADDR_W: sample-store address; read data is valid 1 cycle later.
- `smp_k1`, in, DATA_W: signed sample word 1.
- `smp_k2`, in, DATA_W: signed sample word 2.
- `core_input_k_1`, out, DATA_W: registered input to the core.
- `core_input_k_2`, out, DATA_W: registered input to the core.
- `core_update_coeff`, out, 1: one-cycle update request.
- `core_finish_updating`, in, 1: core update complete.
- `busy`, out, 1: high outside IDLE.
- `done`, out, 1: one-cycle pulse when a run completes normally.
- `err`, out, 1: sticky watchdog error.
- `epoch_cnt`, out, EPOCH_W: epochs completed.
- `sample_idx`, out, ADDR_W: current sample.

## Operation
- States: IDLE, FETCH, LOAD, PULSE, WAIT, DONE.
- IDLE: on `start`, clear `sample_idx`, `epoch_cnt` and `err`, then go to FETCH.
- FETCH: `smp_addr`=`sample_idx`; go to LOAD.
- LOAD: latch `smp_k1`/`smp_k2` into `core_input_k_*`; go to PULSE.
- PULSE: `core_update_coeff`=1 for exactly this cycle; clear the watchdog; go to WAIT.
- WAIT: on `core_finish_updating`=1, advance the counters.
  - If `sample_idx`=N_SAMPLES-1: wrap `sample_idx` to 0 and increment `epoch_cnt`.
  - Otherwise increment `sample_idx`.
  - Go to DONE if the new `epoch_cnt`=N_EPOCHS, else go to FETCH.
- WAIT timeout: if the watchdog reaches TIMEOUT-1 without finish, set `err` and go to IDLE. `done` is not asserted.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `core_input_k_*` hold their value from LOAD until the next LOAD, including through IDLE.
- `core_finish_updating` is ignored outside WAIT, including in the PULSE cycle.
- `abort` in any non-IDLE state goes to IDLE next cycle.
  - `core_update_coeff` is forced 0 that cycle.
  - Counters are frozen, not cleared.
  - `done` is not asserted.
- Abort and finish in the same WAIT cycle: abort wins and counters do not advance.
- `start` while busy: ignored.
- `start` and `abort` together in IDLE: abort wins and the block stays IDLE.
- Arithmetic: counters are unsigned and wrap only as described above. Samples pass through unmodified, with no sign extension or saturation.

## Timing
- Reset (`res`=0 at an edge), all outputs:
  - state IDLE;
  - `smp_addr`=0, `core_input_k_*`=0;
  - `core_update_coeff`=0, `busy`=0, `done`=0, `err`=0;
  - `epoch_cnt`=0, `sample_idx`=0.
- Reset mid-run behaves identically to the above and overrides every other input.
- All outputs are registered.
- `start` sampled at edge 0:
  - edge 1: FETCH, `busy`=1;
  - edge 2: LOAD;
  - edge 3: PULSE, `core_input_k_*` valid;
  - edge 4: WAIT.
- Per-sample overhead: 4 cycles plus core latency. Finish seen at edge n gives FETCH or DONE at edge n+1.
- The watchdog counts WAIT cycles starting at 0 on WAIT entry.

## Structure
- Shared package `nn_pkg`:
  - `DATA_W`=16;
  - the state enum `sched_state_t`;
  - default `TIMEOUT`.
- Sub-module `nn_sched_wdog`: clear/enable counter with a terminal-count flag, parameterised by TIMEOUT.
- The FSM, counters and input registers stay in `nn_train_sched`.

## Test plan
Common setup: N_SAMPLES=4, N_EPOCHS=2, TIMEOUT=32. A behavioural core model raises finish 13 cycles after each update pulse. The store holds {(0,0), (0,0x0100), (0x0100,0), (0x0100,0x0100)}.
- Normal run: `start` -> 8 `core_update_coeff` pulses; per-pulse inputs follow the store order twice; `done` pulses once; `epoch_cnt`=2; `busy` falls with `done`.
- Timing: `core_update_coeff` is first high exactly 3 edges after `start`. Successive pulses are 4+13 cycles apart.
- Watchdog: model never asserts finish -> `err`=1 after 32 WAIT cycles; IDLE; `done`=0; next `start` clears `err`.
- Abort: abort in the same cycle as the 3rd finish -> IDLE; `sample_idx`=2, `epoch_cnt`=0; no `done`; abort in IDLE with `start` -> stays IDLE.
- Reset mid-WAIT: `res`=0 for 1 cycle -> all outputs reach their reset values at the next edge. A spurious finish in IDLE and during PULSE is ignored.
- Negative samples: store (0xFF00, 0x8000) -> `core_input_k_*` equal the store values bit-exact.
